// File: rtl/stream_kernel_dma.sv
// stream_kernel_dma: host-memory -> streaming kernel -> host-memory frame engine.
// Reads a frame into ibuf, streams it to the kernel, captures the kernel output
// into obuf and writes it back. Supports batches of frames, timeout and errors.
module stream_kernel_dma #(
    parameter int unsigned WORD_W  = 64,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [63:0]       read_base,
    input  logic [63:0]       write_base,
    input  logic [63:0]       read_size_input,
    input  logic [63:0]       num_read,
    input  logic [15:0]       num_frames,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [WORD_W-1:0] read_data,
    output logic              read_enable,
    output logic              write_enable,
    output logic              finish_read,
    output logic              finish_write,
    output logic [63:0]       read_addr,
    output logic [63:0]       write_addr,
    output logic [63:0]       read_size_output,
    output logic [63:0]       write_size,
    output logic [WORD_W-1:0] write_data,
    output logic              k_next,
    output logic [WORD_W-1:0] k_in,
    input  logic              k_next_out,
    input  logic [WORD_W-1:0] k_out,
    output logic              done,
    output logic              error
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_WAIT, S_RD_ACK, S_SEND, S_KWAIT,
        S_CAPTURE, S_WR_LOAD, S_WR_WAIT, S_WR_ACK, S_NEXT
    } state_t;

    state_t            state_q;
    logic [63:0]       stride_q;
    logic [CW-1:0]     num_q;
    logic [15:0]       nf_q;
    logic [15:0]       f_q;
    logic [CW-1:0]     idx_q;
    logic [TW-1:0]     kcnt_q;
    logic              read_enable_q, write_enable_q;
    logic              finish_read_q, finish_write_q;
    logic [63:0]       read_addr_q, write_addr_q;
    logic [WORD_W-1:0] write_data_q, k_in_q;
    logic              k_next_q, done_q, error_q;
    logic              last_c;
    logic              bad_len_c;

    logic [WORD_W-1:0] ibuf_q [DEPTH];
    logic [WORD_W-1:0] obuf_q [DEPTH];

    // Current word is the last one of the frame (shared index for all phases)
    assign last_c    = (idx_q + CW'(1)) == num_q;
    assign bad_len_c = (num_read == 64'd0) || (num_read > 64'(DEPTH));

    // Frame buffers: no reset, contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_RD_WAIT && read_ready) begin
            ibuf_q[idx_q[AW-1:0]] <= read_data;
        end
        if (!reset && state_q == S_CAPTURE) begin
            obuf_q[idx_q[AW-1:0]] <= k_out;
        end
    end

    // Main FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            stride_q       <= '0;
            num_q          <= '0;
            nf_q           <= '0;
            f_q            <= '0;
            idx_q          <= '0;
            kcnt_q         <= '0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            finish_read_q  <= 1'b0;
            finish_write_q <= 1'b0;
            read_addr_q    <= '0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            k_in_q         <= '0;
            k_next_q       <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            finish_read_q  <= 1'b0;
            finish_write_q <= 1'b0;
            k_next_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        stride_q <= read_size_input;
                        num_q    <= CW'(num_read);
                        nf_q     <= num_frames;
                        f_q      <= '0;
                        idx_q    <= '0;
                        if (bad_len_c) begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (num_frames == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            read_addr_q   <= read_base;
                            write_addr_q  <= write_base;
                            read_enable_q <= 1'b1;
                            state_q       <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (read_ready) state_q <= S_RD_ACK;
                end
                S_RD_ACK: begin
                    if (!last_c) begin
                        idx_q         <= idx_q + CW'(1);
                        read_addr_q   <= read_addr_q + stride_q;
                        finish_read_q <= 1'b1;
                        state_q       <= S_RD_WAIT;
                    end else begin
                        read_enable_q <= 1'b0;
                        k_next_q      <= 1'b1;
                        idx_q         <= '0;
                        state_q       <= S_SEND;
                    end
                end
                S_SEND: begin
                    k_in_q <= ibuf_q[idx_q[AW-1:0]];
                    if (last_c) begin
                        idx_q   <= '0;
                        kcnt_q  <= '0;
                        state_q <= S_KWAIT;
                    end else begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                S_KWAIT: begin
                    if (k_next_out) begin
                        idx_q   <= '0;
                        state_q <= S_CAPTURE;
                    end else if (kcnt_q == TW'(TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        kcnt_q <= kcnt_q + TW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (last_c) begin
                        idx_q   <= '0;
                        state_q <= S_WR_LOAD;
                    end else begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                S_WR_LOAD: begin
                    write_data_q   <= obuf_q[0];
                    write_enable_q <= 1'b1;
                    state_q        <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (write_ready) state_q <= S_WR_ACK;
                end
                S_WR_ACK: begin
                    if (!last_c) begin
                        finish_write_q <= 1'b1;
                        write_addr_q   <= write_addr_q + stride_q;
                        write_data_q   <= obuf_q[AW'(idx_q + CW'(1))];
                        idx_q          <= idx_q + CW'(1);
                        state_q        <= S_WR_WAIT;
                    end else begin
                        write_enable_q <= 1'b0;
                        state_q        <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // Next frame base is one stride past the last word of this frame
                    if ((f_q + 16'd1) < nf_q) begin
                        f_q           <= f_q + 16'd1;
                        read_addr_q   <= read_addr_q + stride_q;
                        write_addr_q  <= write_addr_q + stride_q;
                        read_enable_q <= 1'b1;
                        idx_q         <= '0;
                        state_q       <= S_RD_WAIT;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign read_enable      = read_enable_q;
    assign write_enable     = write_enable_q;
    assign finish_read      = finish_read_q;
    assign finish_write     = finish_write_q;
    assign read_addr        = read_addr_q;
    assign write_addr       = write_addr_q;
    assign read_size_output = stride_q;
    assign write_size       = stride_q;
    assign write_data       = write_data_q;
    assign k_next           = k_next_q;
    assign k_in             = k_in_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_stream_kernel_dma.sv
// Testbench for stream_kernel_dma: host/kernel responders plus a frame-level model.
module tb_stream_kernel_dma;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 40;
    localparam int          NV      = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [63:0]       read_base, write_base, read_size_input, num_read;
    logic [15:0]       num_frames;
    logic              read_ready, write_ready;
    logic [WORD_W-1:0] read_data;
    logic              read_enable, write_enable, finish_read, finish_write;
    logic [63:0]       read_addr, write_addr, read_size_output, write_size;
    logic [WORD_W-1:0] write_data, k_in, k_out;
    logic              k_next, k_next_out, done, error;

    stream_kernel_dma #(.WORD_W(WORD_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .read_base(read_base), .write_base(write_base),
        .read_size_input(read_size_input), .num_read(num_read), .num_frames(num_frames),
        .read_ready(read_ready), .write_ready(write_ready), .read_data(read_data),
        .read_enable(read_enable), .write_enable(write_enable),
        .finish_read(finish_read), .finish_write(finish_write),
        .read_addr(read_addr), .write_addr(write_addr),
        .read_size_output(read_size_output), .write_size(write_size),
        .write_data(write_data), .k_next(k_next), .k_in(k_in),
        .k_next_out(k_next_out), .k_out(k_out), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] nr;
        logic [15:0] nf;
        logic [63:0] stride;
        logic [63:0] rb;
        logic [63:0] wb;
        int          slo;
        int          shi;
        int          km;   // 0 identity, 1 xor transform, 2 kernel never answers
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Responder state and logs
    int stall_lo = 0, stall_hi = 0, kmode = 0, knum = 0;
    int rd_st = 0, rd_stall = 0, wr_st = 0, wr_stall = 0;
    int kst = 0, kd = 0, ko = 0, kn_cyc = -1;
    int fr_cnt = 0, fw_cnt = 0;
    logic [WORD_W-1:0] kq[$];
    logic [63:0]       rd_log[$];
    logic [63:0]       wr_addr_log[$];
    logic [WORD_W-1:0] wr_data_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WORD_W-1:0] mem_word(input logic [63:0] a);
        logic [63:0] h;
        h = a * 64'h9E37_79B9_7F4A_7C15;
        return WORD_W'(h >> 17) ^ WORD_W'(a);
    endfunction

    function automatic logic [WORD_W-1:0] kfunc(input logic [WORD_W-1:0] x, input int m);
        if (m == 1) return x ^ WORD_W'(64'hA5C3_0F96_5A3C_F069);
        return x;
    endfunction

    function automatic int pick();
        return int'($urandom_range(stall_hi, stall_lo));
    endfunction

    // Host read/write ports and kernel model, evaluated once per cycle
    initial begin
        read_ready = 1'b0; write_ready = 1'b0; read_data = '0;
        k_next_out = 1'b0; k_out = '0;
        forever begin
            @(posedge clk); #1;
            read_ready = 1'b0; write_ready = 1'b0; k_next_out = 1'b0;
            if (reset) begin
                rd_st = 0; wr_st = 0; kst = 0; kq.delete();
            end else begin
                if (finish_read)  fr_cnt++;
                if (finish_write) fw_cnt++;
                if (rd_st == 1 && (finish_read || !read_enable)) begin rd_st = 0; rd_stall = pick(); end
                if (rd_st == 0 && read_enable) begin
                    if (rd_stall == 0) begin
                        read_ready = 1'b1; read_data = mem_word(read_addr);
                        rd_log.push_back(read_addr); rd_st = 1;
                    end else rd_stall--;
                end
                if (wr_st == 1 && (finish_write || !write_enable)) begin wr_st = 0; wr_stall = pick(); end
                if (wr_st == 0 && write_enable) begin
                    if (wr_stall == 0) begin
                        write_ready = 1'b1;
                        wr_addr_log.push_back(write_addr); wr_data_log.push_back(write_data);
                        wr_st = 1;
                    end else wr_stall--;
                end
                case (kst)
                    1: begin kq.push_back(k_in); if (kq.size() == knum) begin kst = 2; kd = 0; end end
                    2: begin kd++; if (kd == 3) begin k_next_out = 1'b1; kst = 3; ko = 0; end end
                    3: begin
                        k_out = kfunc(kq[ko], kmode); ko++;
                        if (ko == knum) begin kst = 0; kq.delete(); end
                    end
                    default: ;
                endcase
                if (k_next && kn_cyc < 0) kn_cyc = cyc;
                if (k_next && kmode != 2) begin kst = 1; kq.delete(); end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic launch(input vec_t v);
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        fr_cnt = 0; fw_cnt = 0; kn_cyc = -1;
        stall_lo = v.slo; stall_hi = v.shi; kmode = v.km; knum = int'(v.nr);
        rd_st = 0; wr_st = 0; rd_stall = pick(); wr_stall = pick();
        num_read = v.nr; num_frames = v.nf; read_size_input = v.stride;
        read_base = v.rb; write_base = v.wb;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_check(input vec_t v);
        bit bad_len, tmo, imm, exp_err;
        int nr, nf, exp_reads, exp_writes, waited, bad, done_cyc;
        bad_len = (v.nr == 64'd0) || (v.nr > 64'(DEPTH));
        imm     = bad_len || (v.nf == 16'd0);
        tmo     = !imm && (v.km == 2);
        exp_err = bad_len || tmo;
        nr = int'(v.nr); nf = int'(v.nf);
        exp_reads  = imm ? 0 : (tmo ? nr : nf * nr);
        exp_writes = (imm || tmo) ? 0 : nf * nr;
        if (imm) check("no_request_after_start", {read_enable, write_enable}, 0);
        else     check("flags_clear_after_start", {done, error}, 0);
        waited = 0;
        while (!done && waited < 20000) begin step(); waited++; end
        done_cyc = cyc;
        check("done_within_budget", done, 1);
        if (!done) begin
            reset = 1'b1; step(); reset = 1'b0; step();
            return;
        end
        if (imm) check("done_latency", 64'(waited), 0);
        check("error_flag", error, exp_err);
        if (tmo) check("timeout_cycles", 64'(done_cyc - kn_cyc), 64'(nr + int'(TIMEOUT)));
        check("read_count", 64'(rd_log.size()), 64'(exp_reads));
        bad = 0;
        for (int k = 0; k < rd_log.size() && k < exp_reads; k++)
            if (rd_log[k] !== v.rb + 64'(k) * v.stride) bad++;
        check("read_addrs_bad", 64'(bad), 0);
        check("write_count", 64'(wr_addr_log.size()), 64'(exp_writes));
        bad = 0;
        for (int k = 0; k < wr_addr_log.size() && k < exp_writes; k++) begin
            if (wr_addr_log[k] !== v.wb + 64'(k) * v.stride) bad++;
            if (wr_data_log[k] !== kfunc(mem_word(v.rb + 64'(k) * v.stride), v.km)) bad++;
        end
        check("write_entries_bad", 64'(bad), 0);
        check("finish_read_pulses", 64'(fr_cnt), 64'(imm ? 0 : (tmo ? nr - 1 : nf * (nr - 1))));
        check("finish_write_pulses", 64'(fw_cnt), 64'(exp_writes == 0 ? 0 : nf * (nr - 1)));
        repeat (3) step();
        check("flags_held", {done, error}, {1'b1, exp_err});
    endtask

    function automatic vec_t mk(input logic [63:0] nr, input logic [15:0] nf, input logic [63:0] stride,
                                input logic [63:0] rb, input logic [63:0] wb,
                                input int slo, input int shi, input int km);
        vec_t v;
        v.nr = nr; v.nf = nf; v.stride = stride; v.rb = rb; v.wb = wb;
        v.slo = slo; v.shi = shi; v.km = km;
        return v;
    endfunction

    vec_t tbl [NV];
    vec_t hv;
    int   w;

    initial begin
        tbl[0] = mk(64'd4, 16'd1, 64'd8, 64'h1000, 64'h2000, 1, 1, 0);
        tbl[1] = mk(64'(DEPTH), 16'd3, 64'd8, 64'h10_0000, 64'h20_0000, 0, 5, 1);
        tbl[2] = mk(64'd0, 16'd1, 64'd8, 64'h3000, 64'h4000, 0, 0, 0);
        tbl[3] = mk(64'(DEPTH + 1), 16'd1, 64'd8, 64'h3000, 64'h4000, 0, 0, 0);
        tbl[4] = mk(64'd4, 16'd0, 64'd8, 64'h3000, 64'h4000, 0, 0, 0);
        tbl[5] = mk(64'd5, 16'd1, 64'd4, 64'h5000, 64'h6000, 0, 2, 2);
        tbl[6] = mk(64'd4, 16'd2, 64'd8, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFE8, 0, 0, 1);
        for (int i = 7; i < NV; i++)
            tbl[i] = mk(64'($urandom_range(DEPTH, 1)), 16'($urandom_range(3, 1)),
                        64'($urandom_range(64, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                        0, 3, 1);

        reset = 1'b1; start = 1'b0;
        num_read = '0; num_frames = '0; read_size_input = '0; read_base = '0; write_base = '0;
        step(); step();
        check("reset_ctrl", {read_enable, write_enable, finish_read, finish_write, k_next, done, error}, 0);
        check("reset_read_addr", read_addr, 0);
        check("reset_write_addr", write_addr, 0);
        check("reset_data", {write_data, k_in}, 0);
        check("reset_size", read_size_output | write_size, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            launch(tbl[i]);
            if (tbl[i].nr != 0 && tbl[i].nr <= 64'(DEPTH) && tbl[i].nf != 0)
                check("size_outputs", read_size_output ^ write_size ^ tbl[i].stride, tbl[i].stride);
            finish_check(tbl[i]);
        end

        // start while busy is ignored and configuration stays latched
        hv = mk(64'd6, 16'd2, 64'd16, 64'h4000, 64'h8000, 4, 6, 1);
        launch(hv);
        step();
        num_read = 64'd1; num_frames = 16'd0; read_base = 64'd0; read_size_input = 64'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start_ignored", {done, read_enable}, 2'b01);
        check("busy_read_addr_held", read_addr, 64'h4000);
        finish_check(hv);

        // reset in the middle of frame 1 write-back
        hv = mk(64'd4, 16'd2, 64'd8, 64'h100, 64'h900, 2, 2, 0);
        launch(hv);
        w = 0;
        while (wr_addr_log.size() < 5 && w < 5000) begin step(); w++; end
        check("reached_frame1_write", 64'(wr_addr_log.size() >= 5), 1);
        reset = 1'b1;
        step();
        check("midreset_ctrl", {read_enable, write_enable, finish_read, finish_write, k_next, done, error}, 0);
        check("midreset_addrs", read_addr | write_addr, 0);
        check("midreset_data", {write_data, k_in}, 0);
        reset = 1'b0;
        step();
        hv = mk(64'd7, 16'd2, 64'd12, 64'h7700, 64'h9900, 0, 2, 1);
        launch(hv);
        finish_check(hv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_kernel_dma.md
# stream_kernel_dma

Parametrised memory-to-kernel-to-memory frame engine for streaming transform accelerators such as the DFT/FFT cores. It reads `num_read` words per frame over the host read handshake into an input buffer and pulses the kernel start. It then streams the frame into the kernel at one word per cycle, captures the kernel's output frame after its ready pulse, and writes it back over the host write handshake. It extends single-frame operation with configurable width and depth, multi-frame batches, an explicit start, a kernel timeout, and an error report.

## Interface
- `WORD_W`, 64, host/kernel word width
- `DEPTH`, 512, buffer depth in words; power of two, maximum frame length
- `TIMEOUT`, 4096, maximum cycles from end of send to `k_next_out`
- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin batch; sampled in IDLE only
- `read_base`, `write_base`  in  64  byte base addresses of frame 0
- `read_size_input`  in  64  byte stride per word, for both read and write
- `num_read`  in  64  words per frame; valid range 1..DEPTH
- `num_frames`  in  16  frames per batch
- `read_ready`, `write_ready`  in  1  host acknowledges the current read or write
- `read_data`  in  WORD_W  read word, valid while `read_ready`=1
- `read_enable`, `write_enable`  out  1  request active
- `finish_read`, `finish_write`  out  1  one-cycle pulse: word consumed, next request follows
- `read_addr`, `write_addr`  out  64  current word address
- `read_size_output`, `write_size`  out  64  copy of the stride
- `write_data`  out  WORD_W  write word
- `k_next`  out  1  one-cycle kernel frame start
- `k_in`  out  WORD_W  kernel input word
- `k_next_out`  in  1  kernel output-frame ready pulse
- `k_out`  in  WORD_W  kernel output word
- `done`  out  1  batch finished; held until the next accepted `start`
- `error`  out  1  batch aborted; held until the next accepted `start`

## Operation
- Reset values: every output is 0; state is IDLE; counters are 0. Buffer contents are not cleared.
- States: IDLE, RD_WAIT, RD_ACK, SEND, KWAIT, CAPTURE, WR_LOAD, WR_WAIT, WR_ACK, NEXT.
- IDLE with `start`=1:
  - Clear `done`/`error`.
  - Latch all configuration inputs. Later changes are ignored until IDLE.
  - If `num_read`=0 or `num_read`>DEPTH, set `error`=1 and `done`=1, stay in IDLE.
  - Otherwise, if `num_frames`=0, set `done`=1, stay in IDLE.
  - Otherwise load the frame read/write addresses, set `read_enable`=1, and go to RD_WAIT.
- RD_WAIT: on `read_ready`=1, write `read_data` to `ibuf[rcnt]` and go to RD_ACK.
- RD_ACK:
  - If `rcnt+1<num_read`: `rcnt`++, `read_addr`+=stride, `finish_read`=1 for one cycle, go to RD_WAIT.
  - Else: `read_enable`=0, `k_next`=1 for one cycle, `rcnt`=0, go to SEND.
- SEND: drive `k_in`=`ibuf[i]` for i=0..num_read-1 on consecutive cycles, then go to KWAIT. `k_in` holds its last value afterwards.
- KWAIT: count cycles.
  - `k_next_out`=1: go to CAPTURE.
  - Count reaches TIMEOUT: set `error`=1 and `done`=1, go to IDLE.
- CAPTURE: `obuf[j]`=`k_out` for j=0..num_read-1 on consecutive cycles, then go to WR_LOAD.
- WR_LOAD: `write_data`=`obuf[0]`, `write_enable`=1, go to WR_WAIT.
- WR_WAIT: on `write_ready`=1, go to WR_ACK.
- WR_ACK:
  - More words remain: `finish_write`=1 for one cycle, `write_addr`+=stride, `write_data`=`obuf[wcnt+1]`, go to WR_WAIT.
  - Else: `write_enable`=0, go to NEXT.
- NEXT:
  - Frame count `f`+1<`num_frames`: frame read base += num_read·stride, frame write base += num_read·stride, reissue the read, go to RD_WAIT.
  - Else: `done`=1, go to IDLE.
- Arithmetic: all addresses are modulo 2^64. Frame offsets accumulate by addition; no multiplier.
- `start` outside IDLE is ignored.
- `reset` asserted mid-batch aborts on the next edge, returns to reset values, and leaves the bus request low.

## Timing
- `read_addr` is valid in the same cycle `read_enable` rises and is stable until `finish_read` or the last word's acknowledge.
- `read_ready` is sampled only in RD_WAIT. A `read_ready` held high still costs 2 cycles per word.
- `k_next` is high in the cycle before `k_in`=`ibuf[0]`.
- The first CAPTURE sample is taken in the cycle after `k_next_out`=1.
- `write_data`/`write_addr` are stable from `write_enable` until the next `finish_write`.
- `write_ready` is sampled only in WR_WAIT.
- `done` and `error` rise in the same cycle. A new `start` may be accepted in the first cycle after `done` rises.

## Test plan
- Single frame, identity kernel model (`k_next_out` 3 cycles after the last `k_in`, `k_out`=input), `num_read`=4, stride 8, read_base 0x1000, write_base 0x2000, ready after 1 cycle -> writes to 0x2000, 0x2008, 0x2010, 0x2018 with the input data in order; exactly 3 `finish_read` and 3 `finish_write` pulses; `done`=1, `error`=0.
- Batch: `num_frames`=3, `num_read`=DEPTH, random ready stalls of 0..5 cycles -> frame 2 reads start at read_base+2·DEPTH·8; all 3·DEPTH words match the model.
- Kernel never pulses `k_next_out` -> `error` and `done` rise exactly TIMEOUT cycles after KWAIT entry; no write is issued.
- `num_read`=0, then `num_read`=DEPTH+1 -> each gives `error`=1 in the cycle after `start`, with no bus activity; a subsequent legal `start` clears both flags.
- `reset` asserted mid-write of frame 1 -> all outputs 0 next cycle; a new batch after reset completes correctly.
- `start` pulsed during RD_WAIT, and `num_frames`=0 -> the first has no effect; the second gives `done`=1 with no requests.
